ddr_rd_burst_arbiter: RTL



---
 rtl/ddr_rd_burst_arbiter_pkg.sv | 37 +++
 rtl/ddr_rd_burst_arbiter_if.sv | 25 ++
 rtl/ddr_rd_burst_arbiter_rr_arbiter.sv | 43 ++++
 rtl/ddr_rd_burst_arbiter.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/ddr_rd_burst_arbiter_pkg.sv
// Shared types and helpers for the DDR read-burst arbiter.
package ddr_arb_pkg;

  localparam int unsigned LEN_WD = 10;
  localparam int unsigned MAX_CH = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StGrant,
    StBurst,
    StDone
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_res_t;

  // First requester strictly after `last` in circular order over `n` channels.
  function automatic rr_res_t rr_next(input logic [MAX_CH-1:0] req, input int unsigned last,
                                      input int unsigned n);
    rr_res_t     res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !res.found && req[idx[2:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ddr_rd_burst_arbiter_if.sv
// Read-burst port between the arbiter and the DDR controller.
interface ddr_rd_burst_arbiter_if #(
  parameter int unsigned ADDR_WD = 32,
  parameter int unsigned DATA_WD = 512
);
  import ddr_arb_pkg::*;

  logic                 rd_burst_req;
  logic [LEN_WD-1:0]    rd_burst_len;
  logic [ADDR_WD-1:0]   rd_burst_addr;
  logic                 rd_burst_data_valid;
  logic [DATA_WD-1:0]   rd_burst_data;
  logic                 rd_burst_finish;

  modport master (
    output rd_burst_req, rd_burst_len, rd_burst_addr,
    input  rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

  modport slave (
    input  rd_burst_req, rd_burst_len, rd_burst_addr,
    output rd_burst_data_valid, rd_burst_data, rd_burst_finish
  );

endinterface

// File: rtl/ddr_rd_burst_arbiter_rr_arbiter.sv
// Round-robin next-grant picker with a registered last-grant pointer.
module rr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              load_i,
  output logic              found_o,
  output logic [CH_W-1:0]   next_id_o,
  output logic [CH_W-1:0]   grant_id_o
);

  logic [CH_W-1:0]   grant_q, grant_d;
  logic [MAX_CH-1:0] req_ext;
  rr_res_t           res;

  // Search starts just after the last owner.
  always_comb begin
    req_ext              = '0;
    req_ext[NUM_CH-1:0]  = req_i;
    res                  = rr_next(req_ext, 32'(grant_q), NUM_CH);
  end

  assign found_o    = res.found;
  assign next_id_o  = CH_W'(res.idx);
  assign grant_id_o = grant_q;

  // Pointer advances only when a grant is taken.
  always_comb begin
    grant_d = load_i ? next_id_o : grant_q;
  end

  // Reset to the last channel so channel 0 wins first.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) grant_q <= CH_W'(NUM_CH - 1);
    else         grant_q <= grant_d;
  end

endmodule

// File: rtl/ddr_rd_burst_arbiter.sv
// Round-robin sharing of one DDR read-burst port among NUM_CH channels.
module ddr_rd_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DDR_ADDR_WD = 32,
  parameter int unsigned DDR_DATA_WD = 512,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CH_W        = $clog2(NUM_CH)
) (
  input  logic                          ddr_clk,
  input  logic                          ddr_rst_n,
  input  logic [NUM_CH-1:0]             ch_rd_burst_req,
  input  logic [NUM_CH*LEN_WD-1:0]      ch_rd_burst_len,
  input  logic [NUM_CH*DDR_ADDR_WD-1:0] ch_rd_burst_addr,
  output logic [NUM_CH-1:0]             ch_rd_burst_data_valid,
  output logic [DDR_DATA_WD-1:0]        ch_rd_burst_data,
  output logic [NUM_CH-1:0]             ch_rd_burst_finish,
  ddr_rd_burst_arbiter_if.master        ctrl,
  output logic [CH_W-1:0]               grant_id,
  output logic                          arb_busy,
  output logic [NUM_CH-1:0]             err_timeout,
  output logic [NUM_CH-1:0]             err_beat,
  input  logic                          err_clr
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;

  arb_state_e               state_q, state_d;
  logic                     req_q, req_d;
  logic                     busy_q, busy_d;
  logic [LEN_WD-1:0]        len_q, len_d;
  logic [DDR_ADDR_WD-1:0]   addr_q, addr_d;
  logic [LEN_WD:0]          beat_q, beat_d;
  logic [WD_W-1:0]          wdog_q, wdog_d;
  logic [NUM_CH-1:0]        err_to_q, err_to_d;
  logic [NUM_CH-1:0]        err_beat_q, err_beat_d;

  logic                     in_burst, beat_in, fin_in, tmo, load, found;
  logic [CH_W-1:0]          next_id;
  logic [LEN_WD:0]          beat_cnt;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr (
    .clk_i      (ddr_clk),
    .rst_ni     (ddr_rst_n),
    .req_i      (ch_rd_burst_req),
    .load_i     (load),
    .found_o    (found),
    .next_id_o  (next_id),
    .grant_id_o (grant_id)
  );

  // Strobes are only honoured while a burst is in flight; the watchdog fires on its last cycle.
  always_comb begin
    in_burst = (state_q == StBurst);
    beat_in  = ctrl.rd_burst_data_valid & in_burst;
    fin_in   = ctrl.rd_burst_finish & in_burst;
    tmo      = in_burst & ~fin_in & (wdog_q == WD_W'(TIMEOUT_CYC - 1));
    beat_cnt = beat_q + (LEN_WD + 1)'(beat_in);
    ch_rd_burst_data_valid           = '0;
    ch_rd_burst_data_valid[grant_id] = beat_in;
    ch_rd_burst_finish               = '0;
    ch_rd_burst_finish[grant_id]     = fin_in | tmo;
  end

  assign ch_rd_burst_data   = ctrl.rd_burst_data;
  assign ctrl.rd_burst_req  = req_q;
  assign ctrl.rd_burst_len  = len_q;
  assign ctrl.rd_burst_addr = addr_q;
  assign arb_busy           = busy_q;
  assign err_timeout        = err_to_q;
  assign err_beat           = err_beat_q;

  // Next-state logic for the FSM, latched burst parameters, counters and error flags.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    busy_d     = busy_q;
    len_d      = len_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    wdog_d     = wdog_q;
    load       = 1'b0;
    err_to_d   = err_clr ? '0 : err_to_q;
    err_beat_d = err_clr ? '0 : err_beat_q;
    unique case (state_q)
      StIdle: if (|ch_rd_burst_req) state_d = StArb;
      StArb: begin
        if (found) begin
          load    = 1'b1;
          len_d   = ch_rd_burst_len[32'(next_id)*LEN_WD +: LEN_WD];
          addr_d  = ch_rd_burst_addr[32'(next_id)*DDR_ADDR_WD +: DDR_ADDR_WD];
          busy_d  = 1'b1;
          state_d = StGrant;
        end else begin
          state_d = StIdle;
        end
      end
      StGrant: begin
        beat_d  = '0;
        wdog_d  = '0;
        req_d   = 1'b1;
        state_d = StBurst;
      end
      StBurst: begin
        beat_d = beat_cnt;
        wdog_d = wdog_q + 1'b1;
        if (fin_in || tmo) begin
          req_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A set in the same cycle as a clear wins.
    if (fin_in && (beat_cnt != {1'b0, len_q})) err_beat_d[grant_id] = 1'b1;
    if (tmo) err_to_d[grant_id] = 1'b1;
  end

  // Single register stage for the FSM and all its registered outputs.
  always_ff @(posedge ddr_clk) begin
    if (!ddr_rst_n) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      len_q      <= '0;
      addr_q     <= '0;
      beat_q     <= '0;
      wdog_q     <= '0;
      err_to_q   <= '0;
      err_beat_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      beat_q     <= beat_d;
      wdog_q     <= wdog_d;
      err_to_q   <= err_to_d;
      err_beat_q <= err_beat_d;
    end
  end

endmodule
